// File: rtl/tt_pkg.sv
// Shared types, defaults and helpers for the truth-table evaluator.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_t;

  localparam int         TT_DEF_N_IN     = 3;
  localparam logic [7:0] TT_DEF_RST_VAL  = 8'h43;
  localparam logic [7:0] TT_DEF_RST_CARE = 8'hF3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/tt_cfg_loader.sv
// Serial table loader: fills a shadow table in ascending order, then
// issues a one-cycle commit strobe so the active table swaps atomically.
module tt_cfg_loader
  import tt_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int IW    = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic             cfg_val,
  input  logic             cfg_care,
  input  logic             cfg_abort,
  output logic [DEPTH-1:0] shadow_val,
  output logic [DEPTH-1:0] shadow_care,
  output logic             commit,
  output logic             busy,
  output logic             done,
  output cfg_state_t       state_dbg
);

  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  cfg_state_t       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [DEPTH-1:0] sv_q, sv_d;
  logic [DEPTH-1:0] sc_q, sc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sv_d    = sv_q;
    sc_d    = sc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        // Abort wins over a same-cycle entry write.
        if (cfg_abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (cfg_valid) begin
          sv_d[idx_q[IW-2:0]] = cfg_val;
          sc_d[idx_q[IW-2:0]] = cfg_care;
          idx_d               = idx_q + IW'(1);
          if (idx_q == LAST_IDX) begin
            state_d = COMMIT;
            done_d  = 1'b1;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sv_q    <= '0;
      sc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sv_q    <= sv_d;
      sc_q    <= sc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign shadow_val  = sv_q;
  assign shadow_care = sc_q;
  assign commit      = done_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign state_dbg   = state_q;

endmodule

// File: rtl/tt_eval_seq.sv
// Registered truth-table evaluator with a run-time reloadable table;
// don't-care entries yield DC_OUT plus out_dc, never X.
module tt_eval_seq
  import tt_pkg::*;
#(
  parameter  int               N_IN     = TT_DEF_N_IN,
  localparam int               DEPTH    = 1 << N_IN,
  parameter  logic [DEPTH-1:0] RST_VAL  = DEPTH'(TT_DEF_RST_VAL),
  parameter  logic [DEPTH-1:0] RST_CARE = DEPTH'(TT_DEF_RST_CARE),
  parameter  logic             DC_OUT   = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_bits,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out,
  output logic            out_dc,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_val,
  input  logic            cfg_care,
  input  logic            cfg_abort,
  output logic            cfg_busy,
  output logic            cfg_done,
  output cfg_state_t      cfg_state_dbg
);

  // Handshake: a beat moves on a port only in a cycle where valid && ready;
  // the producer holds its payload stable while valid && !ready.

  logic [DEPTH-1:0] act_val_q, act_val_d;
  logic [DEPTH-1:0] act_care_q, act_care_d;
  logic [DEPTH-1:0] shadow_val, shadow_care;
  logic             commit;
  logic             out_valid_q, out_valid_d;
  logic             out_q, out_d;
  logic             out_dc_q, out_dc_d;
  logic             accept;
  logic             sel_val, sel_care;

  tt_cfg_loader #(.DEPTH(DEPTH)) u_loader (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_start   (cfg_start),
    .cfg_valid   (cfg_valid),
    .cfg_val     (cfg_val),
    .cfg_care    (cfg_care),
    .cfg_abort   (cfg_abort),
    .shadow_val  (shadow_val),
    .shadow_care (shadow_care),
    .commit      (commit),
    .busy        (cfg_busy),
    .done        (cfg_done),
    .state_dbg   (cfg_state_dbg)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign sel_val  = act_val_q[in_bits];
  assign sel_care = act_care_q[in_bits];

  // The lookup reads the table before the commit edge, so an input taken
  // in the commit cycle still sees the old contents.
  always_comb begin
    act_val_d   = act_val_q;
    act_care_d  = act_care_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_dc_d    = out_dc_q;
    if (commit) begin
      act_val_d  = shadow_val;
      act_care_d = shadow_care;
    end
    if (accept) begin
      out_valid_d = 1'b1;
      out_d       = sel_care ? sel_val : DC_OUT;
      out_dc_d    = !sel_care;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_val_q   <= RST_VAL;
      act_care_q  <= RST_CARE;
      out_valid_q <= 1'b0;
      out_q       <= 1'b0;
      out_dc_q    <= 1'b0;
    end else begin
      act_val_q   <= act_val_d;
      act_care_q  <= act_care_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_dc_q    <= out_dc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_dc    = out_dc_q;

endmodule

// File: tb/tb_tt_eval_seq.sv
// Directed bench for tt_eval_seq: lookup, handshake, reload, abort and reset.
module tb_tt_eval_seq;
  import tt_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_bits;
  logic       out_valid;
  logic       out_ready;
  logic       out;
  logic       out_dc;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_val;
  logic       cfg_care;
  logic       cfg_abort;
  logic       cfg_busy;
  logic       cfg_done;
  cfg_state_t cfg_state_dbg;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int d0;
  logic [1:0] exp_q[$];
  logic [7:0] new_val;

  tt_eval_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_bits       (in_bits),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out           (out),
    .out_dc        (out_dc),
    .cfg_start     (cfg_start),
    .cfg_valid     (cfg_valid),
    .cfg_val       (cfg_val),
    .cfg_care      (cfg_care),
    .cfg_abort     (cfg_abort),
    .cfg_busy      (cfg_busy),
    .cfg_done      (cfg_done),
    .cfg_state_dbg (cfg_state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) if (rst_n && cfg_done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sweep all 8 indices back-to-back; eo/ed are the hand-derived out/out_dc per index.
  task automatic sweep(input string tag, input logic [7:0] eo, input logic [7:0] ed);
    logic [1:0] e;
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        e = exp_q.pop_front();
        check({tag, "_out"}, 32'(out), 32'(e[0]));
        check({tag, "_dc"}, 32'(out_dc), 32'(e[1]));
      end
      if (i < 8) begin
        in_valid = 1'b1;
        in_bits  = 3'(i);
        exp_q.push_back({ed[i], eo[i]});
        #1 check({tag, "_ready"}, 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    new_val   = 8'hA5;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bits   = 3'd0;
    out_ready = 1'b0;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_val   = 1'b0;
    cfg_care  = 1'b0;
    cfg_abort = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_out_dc", 32'(out_dc), 32'd0);
    check("rst_busy", 32'(cfg_busy), 32'd0);
    check("rst_done", 32'(cfg_done), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_state", 32'(cfg_state_dbg), 32'(IDLE));
    rst_n = 1'b1;

    // reset table: out 1,1,0,0,0,0,1,0 ; dc at indices 2,3
    sweep("rst_tbl", 8'b0100_0011, 8'b0000_1100);

    // backpressure
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bits   = 3'b110;
    @(negedge clk);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_out", 32'(out), 32'd1);
    check("bp_dc", 32'(out_dc), 32'd0);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    in_bits = 3'b111;
    @(negedge clk);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_out", 32'(out), 32'd1);
    out_ready = 1'b1;
    #1 check("bp_release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_out", 32'(out), 32'd0);
    check("bp_next_dc", 32'(out_dc), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_drain", 32'(out_valid), 32'd0);

    // abort after 4 entries, abort and valid together on the 5th
    d0 = done_cnt;
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    check("ab_busy", 32'(cfg_busy), 32'd1);
    cfg_valid = 1'b1;
    cfg_val   = 1'b1;
    cfg_care  = 1'b0;
    repeat (4) @(negedge clk);
    check("ab_busy_late", 32'(cfg_busy), 32'd1);
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    cfg_valid = 1'b0;
    check("ab_idle_busy", 32'(cfg_busy), 32'd0);
    check("ab_idle_done", 32'(cfg_done), 32'd0);
    check("ab_idle_state", 32'(cfg_state_dbg), 32'(IDLE));
    sweep("ab_tbl", 8'b0100_0011, 8'b0000_1100);
    check("ab_no_done", 32'(done_cnt - d0), 32'd0);

    // reload A5/FF with gapped entries, then commit race
    d0 = done_cnt;
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int e = 0; e < 8; e++) begin
      check("ld_busy", 32'(cfg_busy), 32'd1);
      check("ld_done_lo", 32'(cfg_done), 32'd0);
      cfg_valid = 1'b1;
      cfg_val   = new_val[e];
      cfg_care  = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      check("ld_gap_busy", 32'(cfg_busy), 32'd1);
      check("ld_gap_done", 32'(cfg_done), (e == 7) ? 32'd1 : 32'd0);
      if (e < 7) @(negedge clk);
    end
    check("ld_commit_state", 32'(cfg_state_dbg), 32'(COMMIT));
    in_valid  = 1'b1;
    in_bits   = 3'd2;
    out_ready = 1'b1;
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    check("ld_after_busy", 32'(cfg_busy), 32'd0);
    check("ld_after_done", 32'(cfg_done), 32'd0);
    check("race_old_valid", 32'(out_valid), 32'd1);
    check("race_old_out", 32'(out), 32'd0);
    check("race_old_dc", 32'(out_dc), 32'd1);
    @(negedge clk);
    check("race_new_out", 32'(out), 32'd1);
    check("race_new_dc", 32'(out_dc), 32'd0);
    in_bits = 3'd0;
    @(negedge clk);
    check("new_idx0_out", 32'(out), 32'd1);
    in_bits = 3'd1;
    @(negedge clk);
    check("new_idx1_out", 32'(out), 32'd0);
    check("new_idx1_dc", 32'(out_dc), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    check("ld_one_done", 32'(done_cnt - d0), 32'd1);

    // asynchronous reset in the middle of a load
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_valid = 1'b1;
    cfg_val   = 1'b1;
    cfg_care  = 1'b1;
    repeat (3) @(negedge clk);
    cfg_valid = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bits   = 3'd5;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    check("mid_pre_out", 32'(out), 32'd1);
    check("mid_pre_busy", 32'(cfg_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out", 32'(out), 32'd0);
    check("mid_rst_dc", 32'(out_dc), 32'd0);
    check("mid_rst_busy", 32'(cfg_busy), 32'd0);
    check("mid_rst_state", 32'(cfg_state_dbg), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    sweep("mid_tbl", 8'b0100_0011, 8'b0000_1100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tt_eval_seq.md
Name: tt_eval_seq

Overview:
- Parametrised, registered truth-table evaluator for the encoder/decoder datapath.
- Maps an N_IN-bit input vector to a 1-bit output through a run-time programmable table of 2^N_IN entries. Each entry has a value bit and a care bit.
- Don't-care entries produce a deterministic output plus a flag, never X.
- The table is reloaded serially through a config FSM into a shadow copy and committed atomically, so evaluation never stalls during a reload.

Parameters:
- N_IN, 3, number of input bits; table depth DEPTH = 2^N_IN; legal range 1..6.
- RST_VAL, 8'h43 (width DEPTH), table value bits after reset; bit i is the entry for input index i.
- RST_CARE, 8'hF3 (width DEPTH), table care bits after reset; 0 marks a don't-care entry.
- DC_OUT, 1'b0, value driven on out for a don't-care entry.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  evaluator can accept an input
- in_bits  in  N_IN  input vector; MSB corresponds to the old "a" input
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out  out  1  table value, or DC_OUT for a don't-care entry
- out_dc  out  1  1 when the addressed entry is a don't-care
- cfg_start  in  1  begin a table reload (IDLE only)
- cfg_valid  in  1  cfg_val/cfg_care hold the next entry
- cfg_val  in  1  entry value bit
- cfg_care  in  1  entry care bit
- cfg_abort  in  1  discard the reload in progress
- cfg_busy  out  1  high in LOAD or COMMIT
- cfg_done  out  1  one-cycle pulse when a commit takes effect

Behaviour:
- Reset (async assert, sync release):
  - active table = RST_VAL/RST_CARE; shadow table = 0.
  - out_valid=0, out=0, out_dc=0, cfg_busy=0, cfg_done=0; FSM in IDLE; entry index = 0.
- Eval handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A transfer occurs when in_valid && in_ready; the registered result is presented with out_valid the next cycle (latency 1).
  - out/out_dc hold stable while out_valid && !out_ready.
  - With out_ready held high, back-to-back inputs give one result per cycle.
  - Without a new transfer, out_valid clears when out_ready=1.
- Lookup: for idx = in_bits:
  - out_dc = !care[idx];
  - out = care[idx] ? val[idx] : DC_OUT.
- Config FSM, states IDLE, LOAD, COMMIT:
  - IDLE: cfg_start -> LOAD, index cleared to 0. cfg_valid in IDLE is ignored.
  - LOAD: each cycle with cfg_valid writes shadow[index] and increments index. When the write hits index DEPTH-1 -> COMMIT. cfg_abort -> IDLE with the active table untouched, and has priority over a same-cycle cfg_valid.
  - COMMIT (1 cycle): shadow copied to the active table; cfg_done=1 for exactly this cycle; -> IDLE. cfg_abort in COMMIT is ignored.
  - cfg_start while busy is ignored.
- Commit visibility:
  - An input accepted in the COMMIT cycle is evaluated with the old table.
  - The new table applies from the next cycle onward.
- Index counter is log2(DEPTH)+1 bits wide and never wraps; entries are always written in ascending order.
- Async reset mid-LOAD: returns to IDLE, active table = RST_VAL/RST_CARE, shadow discarded, any pending out_valid dropped.

Decomposition:
- Shared package tt_pkg holds:
  - cfg_state_t enum (IDLE, LOAD, COMMIT);
  - function clog2;
  - localparams for default N_IN, RST_VAL, RST_CARE.
- Sub-module tt_cfg_loader owns the FSM, index counter and shadow registers. It outputs a shadow bus plus a commit strobe.
- Top level owns the active table, the lookup mux and the output register.

Test Plan:
- Reset defaults: reset, then apply in_bits 0..7 with out_ready=1.
  - Expect out = 1,1,DC,DC,0,0,1,0 and out_dc = 0,0,1,1,0,0,0,0, one result per cycle.
  - out_valid asserts exactly one cycle after each accept.
- Backpressure: out_ready=0 with in_bits=3'b110 accepted.
  - out_valid=1, out=1 held; in_ready=0; a second input 3'b111 is not accepted.
  - Release out_ready: 111 is accepted and yields out=0 the next cycle.
- Reload: cfg_start, then 8 cfg_valid entries giving val=8'hA5, care=8'hFF (cfg_valid gapped every other cycle).
  - cfg_busy high throughout; cfg_done pulses once.
  - Afterwards in_bits=0 -> out=1, in_bits=1 -> out=0.
- Commit race: input idx 2 accepted in the COMMIT cycle -> evaluated with the old table: out=0, out_dc=1.
  - Same idx the next cycle -> new-table value, out_dc=0.
- Abort: abort after 4 entries, with cfg_abort and cfg_valid high together on the 5th cycle.
  - No cfg_done pulse; active table unchanged (reset-default results reproduced).
  - FSM back in IDLE; a subsequent cfg_start loads correctly from index 0.
- Reset mid-LOAD: assert rst_n low asynchronously mid-clock after 3 entries.
  - Outputs clear immediately; table reverts to 8'h43/8'hF3; cfg_busy=0.
